lcd_fb_arbiter: RTL

Owns the single-port frame-buffer RAM between the LCD timing driver and the UART receive path. Every cycle it either serves the driver's pixel read, which always wins, or commits one pending write. It packs UART bytes into RGB565 pixels. It returns RGB888 `pixel_data` to the driver exactly one cycle after the driver presents `pixel_x`/`pixel_y`.

---
 rtl/lcd_fb_pkg.sv | 30 +++
 rtl/lcd_fb_arbiter_if.sv | 24 ++
 rtl/lcd_fb_ram.sv | 22 ++
 rtl/lcd_fb_arbiter.sv | 130 +++++++++++++
 4 files changed

// File: rtl/lcd_fb_pkg.sv
// rtl/lcd_fb_pkg.sv - shared types and helpers for the LCD frame-buffer arbiter
package lcd_fb_pkg;

    typedef enum logic [1:0] {
        HI   = 2'd0,
        LO   = 2'd1,
        PEND = 2'd2
    } wr_state_t;

    localparam logic [23:0] DEFAULT_BG_COLOR = 24'h000000;

    // Address bits needed to cover w*h pixels; never less than one bit.
    function automatic int unsigned fb_aw(input int unsigned w, input int unsigned h);
        int unsigned n;
        int unsigned aw;
        n  = w * h;
        aw = 1;
        for (int i = 1; i < 32; i++) begin
            if ((32'd1 << i) < n) begin
                aw = i + 1;
            end
        end
        return aw;
    endfunction

    function automatic logic [23:0] rgb565_to_888(input logic [15:0] p);
        return {p[15:11], p[15:13], p[10:5], p[10:9], p[4:0], p[4:2]};
    endfunction

endpackage

// File: rtl/lcd_fb_arbiter_if.sv
// rtl/lcd_fb_arbiter_if.sv - driver read port and UART write port of the arbiter
interface lcd_fb_arbiter_if;

    logic [10:0] pixel_x;
    logic [10:0] pixel_y;
    logic [23:0] pixel_data;
    logic        wr_sof;
    logic        wr_valid;
    logic [7:0]  wr_data;
    logic        wr_ready;
    logic        frame_done;
    logic [16:0] wr_addr;

    modport master (
        output pixel_x, pixel_y, wr_sof, wr_valid, wr_data,
        input  pixel_data, wr_ready, frame_done, wr_addr
    );

    modport slave (
        input  pixel_x, pixel_y, wr_sof, wr_valid, wr_data,
        output pixel_data, wr_ready, frame_done, wr_addr
    );

endinterface

// File: rtl/lcd_fb_ram.sv
// rtl/lcd_fb_ram.sv - single-port 16-bit frame-buffer RAM with registered read
module lcd_fb_ram #(
    parameter int unsigned DEPTH = 76800,
    parameter int unsigned AW    = 17
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [15:0]   wdata,
    output logic [15:0]   rdata
);

    logic [15:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/lcd_fb_arbiter.sv
// rtl/lcd_fb_arbiter.sv - frame-buffer port arbiter: LCD reads win, UART RGB565 writes fill idle cycles
module lcd_fb_arbiter
    import lcd_fb_pkg::*;
#(
    parameter int unsigned FB_W     = 320,
    parameter int unsigned FB_H     = 240,
    parameter logic [23:0] BG_COLOR = DEFAULT_BG_COLOR
) (
    input  logic          lcd_pclk,
    input  logic          rst,
    lcd_fb_arbiter_if.slave bus
);

    localparam int unsigned   DEPTH = FB_W * FB_H;
    localparam int unsigned   AW    = fb_aw(FB_W, FB_H);
    localparam logic [AW-1:0] LAST  = AW'(DEPTH - 1);

    wr_state_t     state_q;
    wr_state_t     state_d;
    logic [10:0]   y_m1;
    logic          rd_req;
    logic          out_win;
    logic [AW-1:0] rd_addr;
    logic [AW-1:0] wr_addr_q;
    logic [AW-1:0] ram_addr;
    logic [15:0]   ram_rdata;
    logic [7:0]    hi_byte_q;
    logic [15:0]   pend_pix_q;
    logic          wr_ready_int;
    logic          accept;
    logic          commit;
    logic          ram_we;
    logic          rd_req_q;
    logic          bg_q;
    logic          frame_done_q;

    // pixel_y is 1-based while the driver is requesting, 0 when idle.
    assign y_m1    = bus.pixel_y - 11'd1;
    assign rd_req  = (bus.pixel_y != 11'd0) && (32'(bus.pixel_x) < FB_W) && (32'(y_m1) < FB_H);
    assign out_win = (bus.pixel_y != 11'd0) && !rd_req;
    assign rd_addr = AW'(32'(y_m1) * FB_W + 32'(bus.pixel_x));

    assign wr_ready_int = (state_q != PEND) && !bus.wr_sof;
    assign accept       = bus.wr_valid && wr_ready_int;

    always_comb begin
        state_d = state_q;
        commit  = 1'b0;
        case (state_q)
            HI: begin
                if (accept) begin
                    state_d = LO;
                end
            end
            LO: begin
                if (accept) begin
                    state_d = PEND;
                end
            end
            PEND: begin
                if (!rd_req) begin
                    commit  = 1'b1;
                    state_d = HI;
                end
            end
            default: state_d = HI;
        endcase
        // Start-of-frame throws away any half-built or pending pixel.
        if (bus.wr_sof) begin
            state_d = HI;
            commit  = 1'b0;
        end
    end

    always_ff @(posedge lcd_pclk) begin
        if (rst) begin
            state_q <= HI;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge lcd_pclk) begin
        if (rst) begin
            wr_addr_q    <= '0;
            hi_byte_q    <= 8'd0;
            pend_pix_q   <= 16'd0;
            rd_req_q     <= 1'b0;
            bg_q         <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            rd_req_q     <= rd_req;
            bg_q         <= out_win;
            frame_done_q <= commit && (wr_addr_q == LAST);
            if (bus.wr_sof) begin
                wr_addr_q <= '0;
            end else if (commit) begin
                wr_addr_q <= (wr_addr_q == LAST) ? '0 : wr_addr_q + AW'(1);
            end
            if (accept && (state_q == HI)) begin
                hi_byte_q <= bus.wr_data;
            end
            if (accept && (state_q == LO)) begin
                pend_pix_q <= {hi_byte_q, bus.wr_data};
            end
        end
    end

    // Reads own the port whenever requested; writes only take idle cycles.
    assign ram_we   = commit && !rst;
    assign ram_addr = rd_req ? rd_addr : wr_addr_q;

    lcd_fb_ram #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk   (lcd_pclk),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (pend_pix_q),
        .rdata (ram_rdata)
    );

    assign bus.pixel_data = rd_req_q ? rgb565_to_888(ram_rdata) :
                            bg_q     ? BG_COLOR : 24'h000000;
    assign bus.wr_ready   = wr_ready_int;
    assign bus.frame_done = frame_done_q;
    assign bus.wr_addr    = 17'(wr_addr_q);

endmodule
